// File: rtl/coa_host.sv
// coa_host: issues LFSR operand bursts into the COA core and collects its results.
// Optional max tracking of returned D words is built only when COA_HOST_MAX_EN is defined.
`timescale 1ns/1ps
module coa_host #(
  parameter int N_W      = 6,
  parameter int ACC_W    = 16,
  parameter int DRAIN_TO = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_W-1:0]   num_ops,
  input  logic [14:0]      seed,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ACC_W-1:0] acc,
  output logic [N_W-1:0]   rcv_cnt,
  output logic [9:0]       max_d,
  output logic [4:0]       A,
  output logic [4:0]       B,
  output logic [4:0]       C,
  output logic             valid_in,
  input  logic [9:0]       D,
  input  logic             valid_out,
  output logic [1:0]       dbg_state
);

  // Handshake: valid_in marks one operand triple per cycle with no backpressure;
  // valid_out marks one D word per cycle and is consumed only in ISSUE and DRAIN.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam int TO_W = $clog2(DRAIN_TO + 1);

  state_t           state_q, state_d;
  logic [14:0]      lfsr_q, lfsr_d;
  logic [N_W-1:0]   nops_q, nops_d;
  logic [N_W-1:0]   iss_q, iss_d;
  logic [N_W-1:0]   rcv_q, rcv_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             err_q, err_d;
  logic [TO_W-1:0]  to_q, to_d;

  logic           start_ok, accept, excess, take;
  logic [N_W-1:0] rcv_nxt;

  assign start_ok = (state_q == S_IDLE) && start && (num_ops != '0);
  assign accept   = valid_out && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
  assign excess   = accept && (rcv_q == nops_q);
  assign take     = accept && !excess;
  assign rcv_nxt  = rcv_q + N_W'(take);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    nops_d  = nops_q;
    iss_d   = iss_q;
    rcv_d   = rcv_q;
    acc_d   = acc_q;
    err_d   = err_q;
    to_d    = '0;
    if (take) begin
      rcv_d = rcv_nxt;
      acc_d = acc_q + ACC_W'(D);
    end
    if (excess) err_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          nops_d  = num_ops;
          lfsr_d  = (seed == 15'd0) ? 15'h0001 : seed;
          acc_d   = '0;
          rcv_d   = '0;
          err_d   = 1'b0;
          iss_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
        iss_d  = iss_q + N_W'(1);
        if (iss_q == nops_q - N_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // A result arriving on the expiry cycle completes the command cleanly.
        if (rcv_nxt == nops_q) begin
          state_d = S_DONE;
        end else if (!accept) begin
          if (to_q == TO_W'(DRAIN_TO - 1)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= 15'h0001;
      nops_q  <= '0;
      iss_q   <= '0;
      rcv_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      nops_q  <= nops_d;
      iss_q   <= iss_d;
      rcv_q   <= rcv_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

`ifdef COA_HOST_MAX_EN
  logic [9:0] max_q, max_d_nxt;

  always_comb begin
    max_d_nxt = max_q;
    if (start_ok)               max_d_nxt = '0;
    else if (take && D > max_q) max_d_nxt = D;
  end

  always_ff @(posedge clk) begin
    if (rst) max_q <= '0;
    else     max_q <= max_d_nxt;
  end

  assign max_d = max_q;
`else
  assign max_d = '0;
`endif

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign valid_in  = (state_q == S_ISSUE);
  assign err       = err_q;
  assign acc       = acc_q;
  assign rcv_cnt   = rcv_q;
  assign A         = lfsr_q[4:0];
  assign B         = lfsr_q[9:5];
  assign C         = lfsr_q[14:10];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_coa_host.sv
// Directed bench for coa_host with a 1-cycle stand-in core (D = -(A+B+C) mod 1024)
// and an injection path for hand-placed results.
`timescale 1ns/1ps
module tb_coa_host;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  num_ops = '0;
  logic [14:0] seed = '0;
  logic        busy, done, err, valid_in, valid_out;
  logic [15:0] acc;
  logic [5:0]  rcv_cnt;
  logic [9:0]  max_d, D;
  logic [4:0]  A, B, C;
  logic [1:0]  dbg_state;

  logic        core_en = 1'b1;
  logic        inj_v = 1'b0;
  logic [9:0]  inj_d = '0;
  logic        core_v_q = 1'b0;
  logic [9:0]  core_d_q = '0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

`ifdef COA_HOST_MAX_EN
  localparam bit MAX_EN = 1'b1;
`else
  localparam bit MAX_EN = 1'b0;
`endif

  coa_host dut (
    .clk(clk), .rst(rst), .start(start), .num_ops(num_ops), .seed(seed),
    .busy(busy), .done(done), .err(err), .acc(acc), .rcv_cnt(rcv_cnt),
    .max_d(max_d), .A(A), .B(B), .C(C), .valid_in(valid_in),
    .D(D), .valid_out(valid_out), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // stand-in core: one cycle of latency
  always @(posedge clk) begin
    core_v_q <= valid_in;
    core_d_q <= 10'd0 - (10'(A) + 10'(B) + 10'(C));
  end
  assign valid_out = core_en ? core_v_q : inj_v;
  assign D         = core_en ? core_d_q : inj_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one command starting at a negedge (cycle 0); returns the cycle done was seen.
  task automatic run_cmd(input logic [5:0] n, input logic [14:0] sd, input logic mid,
                         input logic [7:0] inj_mask, output int done_cyc, output int vi_cnt);
    start = 1'b1; num_ops = n; seed = sd;
    @(negedge clk);
    start = 1'b0;
    if (mid) num_ops = 6'd9;
    done_cyc = -1;
    vi_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (valid_in) begin
        vi_cnt++;
        if (exp_q.size() > 0) chk("triple", {17'd0, C, B, A}, exp_q.pop_front());
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      start = mid && (c == 2);
      inj_v = (c < 8) ? inj_mask[c[2:0]] : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    inj_v = 1'b0;
    exp_q.delete();
  endtask

  task automatic expect_cmd(input string tag, input int done_cyc, input int vi_cnt,
                            input int exp_done, input int exp_vi, input int exp_acc,
                            input int exp_rcv, input logic exp_err, input int exp_max);
    chk({tag, "_done_cyc"}, done_cyc, exp_done);
    chk({tag, "_issues"}, vi_cnt, exp_vi);
    chk({tag, "_acc"}, acc, exp_acc);
    chk({tag, "_rcv"}, rcv_cnt, exp_rcv);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_max"}, max_d, MAX_EN ? exp_max : 0);
    chk({tag, "_busy_in_done"}, busy, 1);
    @(negedge clk);
    chk({tag, "_idle_after"}, {busy, done, valid_in}, 3'b000);
    chk({tag, "_err_hold"}, err, exp_err);
    chk({tag, "_acc_hold"}, acc, exp_acc);
  endtask

  initial begin
    int dc, vc;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state", dbg_state, 0);
    chk("rst_flags", {busy, done, err, valid_in}, 4'b0000);
    chk("rst_acc", acc, 0);
    chk("rst_rcv", rcv_cnt, 0);
    chk("rst_max", max_d, 0);

    // single op, seed 1: A=1 -> D=3FF
    exp_q.push_back(32'h0001);
    run_cmd(6'd1, 15'h0001, 1'b0, 8'h00, dc, vc);
    expect_cmd("single", dc, vc, 3, 1, 1023, 1, 1'b0, 1023);

    // zero seed behaves as seed 1
    exp_q.push_back(32'h0001);
    run_cmd(6'd1, 15'h0000, 1'b0, 8'h00, dc, vc);
    expect_cmd("zero_seed", dc, vc, 3, 1, 1023, 1, 1'b0, 1023);

    // two ops, seed 1: D=3FF,3FE
    exp_q.push_back(32'h0001); exp_q.push_back(32'h0002);
    run_cmd(6'd2, 15'h0001, 1'b0, 8'h00, dc, vc);
    expect_cmd("two_ops", dc, vc, 4, 2, 2045, 2, 1'b0, 1023);

    // seed 7FFF: triples 31/31/31 then 30/31/31 -> D=931,932
    exp_q.push_back(32'h7FFF); exp_q.push_back(32'h7FFE);
    run_cmd(6'd2, 15'h7FFF, 1'b0, 8'h00, dc, vc);
    expect_cmd("all_ones", dc, vc, 4, 2, 1863, 2, 1'b0, 932);

    // timeout: no results at all
    core_en = 1'b0;
    run_cmd(6'd3, 15'h0001, 1'b0, 8'h00, dc, vc);
    expect_cmd("timeout", dc, vc, 19, 3, 0, 0, 1'b1, 0);

    // results during ISSUE plus one excess in DRAIN
    inj_d = 10'h200;
    run_cmd(6'd2, 15'h0001, 1'b0, 8'b0000_1110, dc, vc);
    expect_cmd("excess", dc, vc, 4, 2, 1024, 2, 1'b1, 512);
    core_en = 1'b1;

    // start with num_ops=0 is ignored
    start = 1'b1; num_ops = 6'd0; seed = 15'h0001;
    @(negedge clk);
    start = 1'b0;
    chk("zero_n_state", dbg_state, 0);
    chk("zero_n_flags", {busy, valid_in}, 2'b00);
    chk("zero_n_err_kept", err, 1);

    // start pulsed during ISSUE: no extra issues, same timing
    exp_q.push_back(32'h0001); exp_q.push_back(32'h0002);
    exp_q.push_back(32'h0004); exp_q.push_back(32'h0008);
    run_cmd(6'd4, 15'h0001, 1'b1, 8'h00, dc, vc);
    expect_cmd("mid_start", dc, vc, 6, 4, 4081, 4, 1'b0, 1023);

    // reset in cycle 5 of a 20-op burst
    start = 1'b1; num_ops = 6'd20; seed = 15'h0001;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_valid_in", valid_in, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_flags", {busy, done, err, valid_in}, 4'b0000);
    chk("post_rst_acc", acc, 0);
    chk("post_rst_rcv", rcv_cnt, 0);
    chk("post_rst_max", max_d, 0);
    chk("post_rst_state", dbg_state, 0);
    @(negedge clk);
    exp_q.push_back(32'h0001);
    run_cmd(6'd1, 15'h0001, 1'b0, 8'h00, dc, vc);
    expect_cmd("after_rst", dc, vc, 3, 1, 1023, 1, 1'b0, 1023);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
